// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state codes, access-size
// codes and the wait-counter width.
package mem_arb_pkg;

  localparam int WAIT_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_D = 3'd1;
  localparam logic [2:0] ST_BUSY_I = 3'd2;
  localparam logic [2:0] ST_DONE_D = 3'd3;
  localparam logic [2:0] ST_DONE_I = 3'd4;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] DM_FETCH = DM_W;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_BUSY_D) || (st == ST_BUSY_I);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Counts BUSY cycles without an acknowledge; hit flags the cycle on which the
// count would reach the limit, i.e. the last cycle the arbiter waits.
module arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [WAIT_W-1:0] limit,
  output logic              hit
);

  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W:0]   w_next;

  assign w_next = {1'b0, r_cnt} + {{WAIT_W{1'b0}}, 1'b1};
  assign hit    = enable && (w_next == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_next[WAIT_W-1:0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (data load/store over instruction fetch) in front of a
// single registered memory port, with a sticky timeout on missing acknowledges.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_dmtype,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_dmtype,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [2:0]  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_dmtype;
  logic [31:0] r_d_rdata;
  logic [31:0] r_if_rdata;
  logic        r_d_ready;
  logic        r_if_ready;
  logic        r_err;

  logic w_d_any;
  logic w_busy;
  logic w_grant;
  logic w_cnt_en;
  logic w_hit;
  logic w_finish;

  assign w_d_any  = d_read | d_write;
  assign w_busy   = is_busy(r_state);
  assign w_grant  = (r_state == ST_IDLE) && (w_d_any || if_req);
  assign w_cnt_en = w_busy && !mem_ack;
  assign w_finish = w_busy && (mem_ack || w_hit);

  arb_wait_counter u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_grant),
    .enable (w_cnt_en),
    .limit  (LIMIT),
    .hit    (w_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_dmtype <= '0;
      r_d_rdata    <= '0;
      r_if_rdata   <= '0;
      r_d_ready    <= 1'b0;
      r_if_ready   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_d_ready  <= 1'b0;
      r_if_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Data wins; a write overrides a simultaneous read.
          if (w_d_any) begin
            r_state      <= ST_BUSY_D;
            r_mem_req    <= 1'b1;
            r_mem_we     <= d_write;
            r_mem_addr   <= d_addr;
            r_mem_wdata  <= d_wdata;
            r_mem_dmtype <= d_dmtype;
          end else if (if_req) begin
            r_state      <= ST_BUSY_I;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= '0;
            r_mem_dmtype <= DM_FETCH;
          end
        end
        ST_BUSY_D: begin
          if (w_finish) begin
            r_state   <= ST_DONE_D;
            r_mem_req <= 1'b0;
            r_d_ready <= 1'b1;
            r_err     <= r_err | w_hit;
            // Stores leave the load-data register untouched.
            if (!r_mem_we) r_d_rdata <= mem_ack ? mem_rdata : '0;
          end
        end
        ST_BUSY_I: begin
          if (w_finish) begin
            r_state    <= ST_DONE_I;
            r_mem_req  <= 1'b0;
            r_if_ready <= 1'b1;
            r_err      <= r_err | w_hit;
            r_if_rdata <= mem_ack ? mem_rdata : '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_dmtype = r_mem_dmtype;
  assign d_rdata    = r_d_rdata;
  assign d_ready    = r_d_ready;
  assign if_rdata   = r_if_rdata;
  assign if_ready   = r_if_ready;
  assign err        = r_err;

  assign stall = (w_d_any & ~r_d_ready) | (if_req & ~r_if_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_mem_arbiter;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_dmtype = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_dmtype;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        err;

  mem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_dmtype(d_dmtype), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dmtype(mem_dmtype), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks ack_lat cycles after mem_req is first seen (-1 = never).
  int          ack_lat = 0;
  logic [31:0] rd_val = '0;
  bit          inj_ack = 1'b0;
  int          rcnt = 0;
  bit          acked = 1'b0;

  always @(posedge clk) begin
    #2;
    mem_ack = inj_ack;
    if (inj_ack) mem_rdata = 32'hBAD0BAD0;
    if (mem_req && !acked) begin
      if (rcnt == ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
        acked     = 1'b1;
      end
      rcnt++;
    end else if (!mem_req) begin
      rcnt  = 0;
      acked = 1'b0;
    end
  end

  // Transaction model: phase 0 = waiting for a request, 1 = memory access in
  // flight, 2 = completion cycle. Outputs follow from the phase and owner.
  int          m_phase = 0;
  bit          m_own_d = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_drd = '0, m_ird = '0;
  logic [2:0]  m_dm = '0;
  bit          m_err = 1'b0;
  int          m_wait = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_dm = '0; m_drd = '0; m_ird = '0; m_err = 0; m_wait = 0;
    end else begin
      case (m_phase)
        0: begin
          if (d_read || d_write) begin
            m_own_d = 1; m_we = d_write; m_addr = d_addr; m_wdata = d_wdata;
            m_dm = d_dmtype; m_wait = 0; m_phase = 1;
          end else if (if_req) begin
            m_own_d = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
            m_dm = 3'b010; m_wait = 0; m_phase = 1;
          end
        end
        1: begin
          if (mem_ack) begin
            if (m_own_d) begin
              if (!m_we) m_drd = mem_rdata;
            end else m_ird = mem_rdata;
            m_phase = 2;
          end else begin
            m_wait++;
            if (m_wait == MAXW) begin
              m_err = 1;
              if (m_own_d) begin
                if (!m_we) m_drd = '0;
              end else m_ird = '0;
              m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit e_req, e_dr, e_ir, e_stall;
      e_req   = (m_phase == 1);
      e_dr    = (m_phase == 2) && m_own_d;
      e_ir    = (m_phase == 2) && !m_own_d;
      e_stall = ((d_read | d_write) & ~e_dr) | (if_req & ~e_ir);
      chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
      chk("d_ready", {31'b0, d_ready}, {31'b0, e_dr});
      chk("if_ready", {31'b0, if_ready}, {31'b0, e_ir});
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("d_rdata", d_rdata, m_drd);
      chk("if_rdata", if_rdata, m_ird);
      if (e_req) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_dmtype", {29'b0, mem_dmtype}, {29'b0, m_dm});
      end
    end
  end

  // Event monitor feeding the literal checks.
  int          cnt_req = 0, cnt_dr = 0, cnt_ir = 0, cyc_no = 0, t_dr = 0, t_ir = 0;
  logic [31:0] last_drd = '0, last_ird = '0;
  logic [31:0] addr_q[$];
  bit          we_q[$];
  bit          prev_req = 1'b0;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && !prev_req) begin
      addr_q.push_back(mem_addr);
      we_q.push_back(mem_we);
    end
    prev_req = (mem_req === 1'b1);
    if (mem_req === 1'b1) cnt_req++;
    if (d_ready === 1'b1) begin cnt_dr++; t_dr = cyc_no; last_drd = d_rdata; end
    if (if_ready === 1'b1) begin cnt_ir++; t_ir = cyc_no; last_ird = if_rdata; end
    cyc_no++;
  end

  task automatic clear_mon();
    cnt_req = 0; cnt_dr = 0; cnt_ir = 0;
    addr_q.delete(); we_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit is_d, input int n, input string nm);
    int k = 0;
    while (((is_d ? cnt_dr : cnt_ir) < n) && k < 60) begin
      cyc();
      k++;
    end
    chk({nm, "_completed"}, {31'b0, ((is_d ? cnt_dr : cnt_ir) >= n)}, 32'd1);
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    reset = 1'b0;
    cyc();

    // Single load, ack one cycle after mem_req; address changes mid-access
    clear_mon();
    ack_lat = 1; rd_val = 32'hDEADBEEF;
    d_read = 1'b1; d_addr = 32'h100; d_dmtype = 3'b010;
    cyc();
    d_addr = 32'h999;
    wait_rdy(1'b1, 1, "load");
    d_read = 1'b0;
    cyc();
    chk("load_req_cycles", cnt_req, 32'd2);
    chk("load_rdata", last_drd, 32'hDEADBEEF);
    chk("load_addr", addr_q[0], 32'h100);
    chk("load_stall_after", {31'b0, stall}, 32'd0);

    // Simultaneous store and fetch: data first, fetch after
    clear_mon();
    ack_lat = 0; rd_val = 32'h55555555;
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_dmtype = 3'b001;
    if_req = 1'b1; if_addr = 32'h0;
    begin
      int k = 0;
      while (!(cnt_dr >= 1 && cnt_ir >= 1) && k < 60) begin
        cyc();
        if (cnt_dr >= 1) d_write = 1'b0;
        if (cnt_ir >= 1) if_req = 1'b0;
        k++;
      end
    end
    chk("arb_both_done", {31'b0, (cnt_dr == 1 && cnt_ir == 1)}, 32'd1);
    chk("arb_first_addr", addr_q[0], 32'h200);
    chk("arb_first_we", {31'b0, we_q[0]}, 32'd1);
    chk("arb_second_addr", addr_q[1], 32'h0);
    chk("arb_second_we", {31'b0, we_q[1]}, 32'd0);
    chk("arb_order", {31'b0, (t_ir > t_dr)}, 32'd1);
    chk("store_keeps_drdata", d_rdata, 32'hDEADBEEF);
    chk("fetch_rdata", last_ird, 32'h55555555);

    // Fetch with no ack: timeout after MAX_WAIT busy cycles
    clear_mon();
    ack_lat = -1;
    if_req = 1'b1; if_addr = 32'h80;
    wait_rdy(1'b0, 1, "timeout");
    if_req = 1'b0;
    cyc();
    chk("timeout_req_cycles", cnt_req, 32'd15);
    chk("timeout_err", {31'b0, err}, 32'd1);
    chk("timeout_rdata", last_ird, 32'd0);

    // Next fetch completes normally, err stays set
    clear_mon();
    ack_lat = 2; rd_val = 32'hCAFEF00D;
    if_req = 1'b1; if_addr = 32'h40;
    wait_rdy(1'b0, 1, "post_timeout");
    if_req = 1'b0;
    cyc();
    chk("post_timeout_rdata", last_ird, 32'hCAFEF00D);
    chk("post_timeout_req_cycles", cnt_req, 32'd3);
    chk("err_sticky", {31'b0, err}, 32'd1);

    // Stray ack while idle
    clear_mon();
    inj_ack = 1'b1;
    cyc();
    inj_ack = 1'b0;
    cyc(); cyc();
    chk("stray_ack_no_ready", cnt_dr + cnt_ir, 32'd0);
    chk("stray_ack_no_req", cnt_req, 32'd0);
    chk("stray_ack_ifrdata", if_rdata, 32'hCAFEF00D);

    // Reset during a load, ack arrives afterwards
    clear_mon();
    ack_lat = -1;
    d_read = 1'b1; d_addr = 32'h300;
    cyc(); cyc();
    chk("busy_before_reset", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0; d_read = 1'b0; inj_ack = 1'b1;
    cyc();
    inj_ack = 1'b0;
    cyc(); cyc();
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_no_ready", cnt_dr, 32'd0);
    chk("abort_err_clear", {31'b0, err}, 32'd0);
    chk("abort_drdata", d_rdata, 32'd0);

    // Back-to-back loads with the request held through d_ready
    clear_mon();
    ack_lat = 0; rd_val = 32'h11111111;
    d_read = 1'b1; d_addr = 32'h400;
    wait_rdy(1'b1, 1, "b2b_first");
    rd_val = 32'h22222222;
    wait_rdy(1'b1, 2, "b2b_second");
    d_read = 1'b0;
    cyc(); cyc(); cyc();
    chk("b2b_ready_count", cnt_dr, 32'd2);
    chk("b2b_grants", addr_q.size(), 32'd2);
    chk("b2b_req_cycles", cnt_req, 32'd2);
    chk("b2b_last_rdata", last_drd, 32'h22222222);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
